// File: rtl/tmds_channel_decoder_if.sv
// Deserializer-to-sink bundle for one TMDS channel: raw 10-bit words in,
// decoded pixel/control/alignment status out.
interface tmds_channel_decoder_if;
  logic [9:0] tmds_in;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  modport master (output tmds_in, input data, ctl, de, locked, offset);
  modport slave  (input tmds_in, output data, ctl, de, locked, offset);
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment by control-token run detection,
// followed by 10b->8b decode into data, control bits and data-enable.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT   = 16,
  parameter int SLIP_WINDOW  = 1024,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic                   pixclk,
  input  logic                   rst_n,
  tmds_channel_decoder_if.slave  bus
);

  localparam int RUN_W  = $clog2(LOCK_COUNT);
  localparam int SLIP_W = $clog2(SLIP_WINDOW);
  localparam int GAP_W  = $clog2(LOSS_TIMEOUT);

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [9:0]  prev_q, a_q;
  logic        a_tok_q;
  logic [1:0]  a_val_q;
  logic [7:0]  data_q, data_d;
  logic [1:0]  ctl_q, ctl_d;
  logic        de_q, de_d, locked_q, locked_d;

  logic [19:0] window;
  logic [9:0]  a;
  logic        is_tok;
  logic [1:0]  tok_val;

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] t, d;
    t    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  // The current offset selects from the live window, so a slip takes effect
  // on the very next classified word.
  assign window = {bus.tmds_in, prev_q};
  assign a      = 10'(window >> offset_q);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (a)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      offset_q   <= '0;
      run_cnt_q  <= '0;
      slip_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      run_cnt_q  <= run_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    run_cnt_d  = run_cnt_q;
    slip_cnt_d = slip_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    unique case (state_q)
      SEARCH: begin
        if (is_tok) begin
          slip_cnt_d = '0;
          if (run_cnt_q == RUN_W'(LOCK_COUNT - 1)) begin
            state_d   = LOCKED;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else begin
          run_cnt_d = '0;
          if (slip_cnt_q == SLIP_W'(SLIP_WINDOW - 1)) begin
            slip_cnt_d = '0;
            offset_d   = (offset_q == 4'd9) ? 4'd0 : offset_q + 1'b1;
          end else begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (is_tok) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_W'(LOSS_TIMEOUT - 1)) begin
          // Resume searching from the offset we held; counters start fresh.
          state_d    = SEARCH;
          gap_cnt_d  = '0;
          run_cnt_d  = '0;
          slip_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    data_d   = 8'h00;
    ctl_d    = ctl_q;
    de_d     = 1'b0;
    locked_d = (state_q == LOCKED);
    if (state_q == LOCKED) begin
      if (a_tok_q) begin
        ctl_d = a_val_q;
      end else begin
        de_d   = 1'b1;
        data_d = decode(a_q);
      end
    end else begin
      ctl_d = 2'b00;
    end
  end

  // NOTE: pipeline and output registers are all reset so outputs are clean from the first edge.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      a_q      <= '0;
      a_tok_q  <= 1'b0;
      a_val_q  <= '0;
      data_q   <= '0;
      ctl_q    <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= bus.tmds_in;
      a_q      <= a;
      a_tok_q  <= is_tok;
      a_val_q  <= tok_val;
      data_q   <= data_d;
      ctl_q    <= ctl_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.ctl    = ctl_q;
  assign bus.de     = de_q;
  assign bus.locked = locked_q;
  assign bus.offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder against a word-stream reference
// model, with directed lock, decode, loss and reset scenarios.
module tb_tmds_channel_decoder;

  localparam int LOCK_COUNT   = 16;
  localparam int SLIP_WINDOW  = 1024;
  localparam int LOSS_TIMEOUT = 4096;

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;

  tmds_channel_decoder_if bus ();

  tmds_channel_decoder #(
    .LOCK_COUNT  (LOCK_COUNT),
    .SLIP_WINDOW (SLIP_WINDOW),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .pixclk(pixclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 pixclk = ~pixclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ctl;
    logic       de;
    logic       locked;
  } out_t;

  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  out_t       pipe_q [$];
  out_t       exp_o;
  int         m_off, m_run, m_slip, m_gap;
  bit         m_lk;
  logic [9:0] m_prev;
  logic [1:0] m_ctl;

  function automatic bit token(input logic [9:0] a, output logic [1:0] v);
    v = 2'b00;
    for (int i = 0; i < 4; i++)
      if (a == toks[i]) begin
        v = 2'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] a);
    logic [7:0] t, d;
    t = a[9] ? ~a[7:0] : a[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = (t[i] ^ t[i-1]) ^ ~a[8];
    return d;
  endfunction

  task automatic model_reset();
    m_off = 0; m_run = 0; m_slip = 0; m_gap = 0; m_lk = 0;
    m_prev = '0; m_ctl = '0;
    exp_o = '0;
    pipe_q.delete();
    pipe_q.push_back('0);
  endtask

  // Applies one clock edge with word w on the input.
  task automatic model_edge(input logic [9:0] w);
    logic [19:0] win;
    logic [9:0]  a;
    logic [1:0]  v;
    bit          tk;
    out_t        o;
    win = {w, m_prev};
    a   = 10'(win >> m_off);
    tk  = token(a, v);
    if (!m_lk) begin
      if (tk) begin
        m_slip = 0;
        m_run++;
        if (m_run == LOCK_COUNT) begin m_lk = 1; m_run = 0; end
      end else begin
        m_run = 0;
        m_slip++;
        if (m_slip == SLIP_WINDOW) begin m_off = (m_off + 1) % 10; m_slip = 0; end
      end
    end else begin
      m_gap = tk ? 0 : m_gap + 1;
      if (m_gap == LOSS_TIMEOUT) begin m_lk = 0; m_gap = 0; end
    end
    o = '0;
    if (m_lk) begin
      o.locked = 1'b1;
      if (tk) m_ctl = v;
      else begin o.de = 1'b1; o.data = dec(a); end
    end else begin
      m_ctl = 2'b00;
    end
    o.ctl  = m_ctl;
    exp_o  = pipe_q.pop_front();
    pipe_q.push_back(o);
    m_prev = w;
  endtask

  task automatic compare_all();
    check("data",   32'(bus.data),   32'(exp_o.data));
    check("ctl",    32'(bus.ctl),    32'(exp_o.ctl));
    check("de",     32'(bus.de),     32'(exp_o.de));
    check("locked", 32'(bus.locked), 32'(exp_o.locked));
    check("offset", 32'(bus.offset), 32'(m_off));
  endtask

  task automatic check_zero(input string name);
    check({name, "_data"},   32'(bus.data),   0);
    check({name, "_ctl"},    32'(bus.ctl),    0);
    check({name, "_de"},     32'(bus.de),     0);
    check({name, "_locked"}, 32'(bus.locked), 0);
    check({name, "_offset"}, 32'(bus.offset), 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [9:0] w);
    @(negedge pixclk);
    if (rst_n) compare_all();
    bus.tmds_in = w;
    if (rst_n) model_edge(w);
  endtask

  task automatic after_edge();
    @(posedge pixclk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge pixclk);
    rst_n = 1'b1;
    model_reset();
    model_edge(bus.tmds_in);
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] v;
    do w = 10'($urandom); while (token(w, v));
    return w;
  endfunction

  logic [9:0] tok00, rot;
  int n;

  initial begin
    bus.tmds_in = '0;
    model_reset();

    // Reset held with random input: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      step(10'($urandom));
      after_edge();
      check_zero("in_reset");
    end

    // Aligned lock: release with token 1 on the bus, tokens follow.
    tok00 = toks[0];
    step(tok00);
    release_reset();
    for (int i = 2; i <= 20; i++) begin
      step(tok00);
      after_edge();
      if (i == 17) check("lock_early", 32'(bus.locked), 0);
      if (i == 18) begin
        check("lock_rise",   32'(bus.locked), 1);
        check("lock_offset", 32'(bus.offset), 0);
        check("lock_ctl",    32'(bus.ctl),    0);
        check("lock_de",     32'(bus.de),     0);
      end
    end

    // Directed decode, two edges after capture.
    step(10'b0100000000);
    step(10'b1000000000);
    step(10'b0010101011);
    after_edge();
    check("dec0_de",   32'(bus.de),   1);
    check("dec0_data", 32'(bus.data), 32'h00);
    step(tok00);
    after_edge();
    check("decff_de",   32'(bus.de),   1);
    check("decff_data", 32'(bus.data), 32'hFF);
    step(tok00);
    after_edge();
    check("tok01_de",   32'(bus.de),   0);
    check("tok01_data", 32'(bus.data), 0);
    check("tok01_ctl",  32'(bus.ctl),  1);

    // 4095 data symbols then a token: lock held.
    for (int i = 0; i < LOSS_TIMEOUT - 1; i++) step(rand_data());
    step(tok00);
    step(tok00);
    step(tok00);
    after_edge();
    check("gap_held", 32'(bus.locked), 1);

    // 4096 data symbols: lock dropped on the output of the last one.
    for (int i = 0; i < LOSS_TIMEOUT; i++) step(rand_data());
    step(rand_data());
    after_edge();
    check("loss_before", 32'(bus.locked), 1);
    step(rand_data());
    after_edge();
    check("loss_locked", 32'(bus.locked), 0);
    check("loss_de",     32'(bus.de),     0);

    // Randomized bursts of tokens and data symbols.
    n = 0;
    while (n < 3000) begin
      int tl, dl;
      tl = int'($urandom_range(0, 24));
      dl = int'($urandom_range(1, 40));
      for (int i = 0; i < tl; i++) step(toks[$urandom_range(0, 3)]);
      for (int i = 0; i < dl; i++) step(10'($urandom));
      n += tl + dl;
    end

    // Skewed lock: symbols start at bit 3 of each word.
    @(negedge pixclk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    rot = {tok00[6:0], tok00[9:7]};
    for (int i = 0; i < 3; i++) step(10'($urandom));
    step(rot);
    release_reset();
    n = 0;
    while (!bus.locked && n < 3 * SLIP_WINDOW + 40) begin
      step(rot);
      after_edge();
      n++;
    end
    check("skew_locked", 32'(bus.locked), 1);
    check("skew_offset", 32'(bus.offset), 3);
    check("skew_time_max", 32'(n <= 3 * SLIP_WINDOW + LOCK_COUNT + 2), 1);
    check("skew_time_min", 32'(n >= 3 * SLIP_WINDOW), 1);
    for (int i = 0; i < 4; i++) step(rot);
    after_edge();

    // Asynchronous reset while locked at offset 3.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    step(10'($urandom));
    step(10'($urandom));
    release_reset();
    for (int i = 0; i < 30; i++) step(tok00);
    @(negedge pixclk);
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
